// File: rtl/bcd_stopwatch.sv
// Single-clock multi-digit BCD stopwatch with debounced start/stop, clear and lap
// buttons, wrap or saturate on overflow, and a multiplexed active-low 7-segment output.
module bcd_stopwatch #(
    parameter int DIGITS       = 4,
    parameter int TICK_DIV     = 65536,
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_DIV = 65536,
    parameter bit WRAP         = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_stop,
    input  logic              clear,
    input  logic              lap,
    output logic [7:0]        LED,
    output logic [DIGITS-1:0] selecters,
    output logic              overflow,
    output logic              running
);

    localparam int DW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Button vectors are ordered {lap, clear, start_stop}.
    logic [2:0]    btn_raw;
    logic [2:0]    sync1, sync2, sample_q, armed, press;
    logic [1:0]    sync_valid;
    logic [DW-1:0] deb_cnt;
    logic          deb_strobe;

    logic [TW-1:0] tick_cnt;
    logic          tick_strobe;
    logic [SW-1:0] scan_cnt;
    logic          scan_strobe;
    logic [IW-1:0] scan_idx;

    logic [DIGITS-1:0][3:0] count, latch, count_inc;
    logic                   all_nines;
    logic                   carry;
    logic                   freeze;
    logic                   step;
    logic                   clear_ok;
    logic [3:0]             shown;

    assign btn_raw     = {lap, clear, start_stop};
    assign deb_strobe  = (deb_cnt == DW'(DEBOUNCE_DIV - 1));
    assign tick_strobe = (tick_cnt == TW'(TICK_DIV - 1));
    assign scan_strobe = (scan_cnt == SW'(SCAN_DIV - 1));

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // A button only arms after a valid 0 sample, so a press held through reset
    // release has to be let go before it can produce a pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            sync_valid <= '0;
            sample_q   <= '0;
            armed      <= '0;
            press      <= '0;
            deb_cnt    <= '0;
        end else begin
            sync1      <= btn_raw;
            sync2      <= sync1;
            sync_valid <= {sync_valid[0], 1'b1};
            press      <= '0;
            deb_cnt    <= deb_strobe ? '0 : deb_cnt + DW'(1);
            if (deb_strobe) begin
                sample_q <= sync2;
                press    <= sync2 & ~sample_q & armed;
                if (sync_valid[1]) armed <= armed | ~sync2;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            scan_cnt <= '0;
            scan_idx <= '0;
        end else begin
            tick_cnt <= tick_strobe ? '0 : tick_cnt + TW'(1);
            scan_cnt <= scan_strobe ? '0 : scan_cnt + SW'(1);
            if (scan_strobe) begin
                scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
            end
        end
    end

    always_comb begin
        count_inc = count;
        all_nines = 1'b1;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count[i] != 4'd9) all_nines = 1'b0;
            if (carry) begin
                if (count[i] == 4'd9) begin
                    count_inc[i] = 4'd0;
                end else begin
                    count_inc[i] = count[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
    end

    // Both the strobe and the clear gate look at running before this cycle's toggle.
    assign step     = tick_strobe & running;
    assign clear_ok = press[1] & ~running;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            latch    <= '0;
            overflow <= 1'b0;
            running  <= 1'b0;
            freeze   <= 1'b0;
        end else begin
            if (clear_ok) begin
                count <= '0;
            end else if (step) begin
                if (!all_nines) count <= count_inc;
                else if (WRAP)  count <= '0;
            end

            if (clear_ok)               overflow <= 1'b0;
            else if (step && all_nines) overflow <= 1'b1;

            if (press[0])                        running <= ~running;
            else if (step && all_nines && !WRAP) running <= 1'b0;

            if (clear_ok) begin
                freeze <= 1'b0;
            end else if (press[2]) begin
                if (running) begin
                    freeze <= ~freeze;
                    if (!freeze) latch <= count;
                end else begin
                    freeze <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        shown = freeze ? latch[scan_idx] : count[scan_idx];
    end

    // LED and selecters share one register stage so the digit and its enable move together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            LED       <= 8'b0000_0011;
            selecters <= ~DIGITS'(1);
        end else begin
            LED       <= {seg7(shown), ~freeze};
            selecters <= ~(DIGITS'(1) << scan_idx);
        end
    end

endmodule

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Parametrised multi-digit decimal stopwatch with multiplexed 7-segment output. It replaces the fixed 4-digit ripple-clocked counter with a fully synchronous single-clock design. It adds debounced start/stop, clear and lap (display freeze) buttons, a selectable wrap/saturate mode on overflow, and a configurable digit count and scan rate. It sits between the board buttons and the 7-segment display connector.

## Interface
- DIGITS, 4: number of BCD digits (1..8); digit 0 is least significant.
- TICK_DIV, 65536: clock cycles per count increment.
- SCAN_DIV, 4: clock cycles per display digit slot.
- DEBOUNCE_DIV, 65536: clock cycles between button samples.
- WRAP, 1: 1 = wrap to zero on overflow and keep running; 0 = saturate at all-9s and stop.
- clock  in  1  sole clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start_stop  in  1  raw button; each press toggles running.
- clear  in  1  raw button; zeroes the count when stopped.
- lap  in  1  raw button; toggles display freeze.
- LED  out  8  active-low segments {a,b,c,d,e,f,g,dp} for the selected digit, LED[7]=a.
- selecters  out  DIGITS  active-low one-hot digit enable.
- overflow  out  1  sticky overflow flag.
- running  out  1  counting enabled.

## Operation
- Buttons:
  - Each button passes through a 2-flop synchroniser.
  - The synchronised level is sampled when the debounce prescaler (0..DEBOUNCE_DIV-1, free-running) reaches DEBOUNCE_DIV-1.
  - A sample of 1 following a previous sample of 0 yields a one-cycle press pulse.
- Tick: the tick prescaler (0..TICK_DIV-1) is free-running and independent of run. Its strobe fires at TICK_DIV-1.
- Count: on a strobe with running=1, the DIGITS-digit BCD value increments by 1 with carry ripple inside one cycle. Each digit holds 0..9.
- At all-9s with a strobe and running=1:
  - WRAP=1: count becomes 0, overflow sets, running unchanged.
  - WRAP=0: count holds all-9s, overflow sets, running clears.
- start_stop press toggles running. A strobe in the same cycle uses the pre-toggle running value.
- clear press:
  - When running=0: count, overflow and freeze all clear.
  - When running=1: ignored.
  - clear and start_stop pressed in the same cycle while stopped: count clears and running sets.
- lap press:
  - When running=1: toggles freeze. Freeze entry copies the live count to the display latch.
  - When running=0: clears freeze only.
- Display source: the latch when freeze=1, otherwise the live count.
- Scan:
  - The scan index advances every SCAN_DIV cycles over 0..DIGITS-1 and wraps to 0.
  - selecters[index]=0 and all other selecters are 1.
  - LED shows the segments of the indexed digit.
  - dp (LED[0]) is 0 on every digit while freeze=1, otherwise 1.
- Decode (active-low, bits a..g, dp excluded): 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100.

## Timing
- reset_n low, asynchronously:
  - all prescalers and the scan index go to 0; count and latch go to 0.
  - running=0, overflow=0, freeze=0, synchroniser and sample flops cleared.
  - selecters = all 1 except bit 0 = 0; LED = 8'b00000011.
- Reset mid-count or mid-press: all state is lost. A button held through reset release gives no pulse until it is released and pressed again.
- Button latency: a level change reaches the sampler after 2 cycles. The pulse occurs in the cycle after the sample, and the state update lands on the following edge.
- Count latency: the count changes on the edge ending the strobe cycle.
- running and overflow are registered.
- Display updates within one cycle of a count or index change; LED and selecters are registered together, so no skew.

## Test plan
- Params DIGITS=2, TICK_DIV=4, DEBOUNCE_DIV=1, SCAN_DIV=2. Press start_stop, run 40 strobes → count 40, running=1, overflow=0.
- Same params, WRAP=1. Start from 0 and run 100 strobes → count 00, overflow=1, running=1. Then stop and clear → overflow=0.
- WRAP=0, 120 strobes → count 99 from strobe 99 onward, running=0 after strobe 100, overflow=1.
- Lap at count 12, 5 more strobes:
  - display reads 12 with dp=0 while the live count is 17;
  - second lap → display 17 with dp=1.
- clear while running → no change. Stop, then clear → count 00. A glitchy press (1-cycle pulses between samples with DEBOUNCE_DIV=8) → at most one toggle.
- Assert reset_n mid-scan with count 57 → outputs immediately read selecters=2'b10, LED=8'b00000011, running=0.
